// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial word receiver.
// The PARITY state exists only when SERIAL_WORD_RX_PARITY_EN is defined.
package serial_rx_pkg;

    localparam int SERIAL_WORD_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef SERIAL_WORD_RX_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } rxState_t;

endpackage

// File: rtl/serial_word_rx.sv
// Strobe-driven serial word receiver: start strobe, then WORD_W data strobes MSB-first.
// Define SERIAL_WORD_RX_PARITY_EN to append and check one even-parity bit per frame.
module serial_word_rx
    import serial_rx_pkg::*;
#(
    parameter int WORD_W = SERIAL_WORD_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_bit,
    input  logic                        zero_bit,
    input  logic                        one_bit,
    output logic [WORD_W-1:0]           out_word,
    output logic                        word_valid,
    output logic                        frame_err,
    output logic                        busy,
    output logic [$clog2(WORD_W+2)-1:0] bits_left
);

    localparam int CNT_W = $clog2(WORD_W + 2);
`ifdef SERIAL_WORD_RX_PARITY_EN
    localparam int FRAME_LEN = WORD_W + 1;
`else
    localparam int FRAME_LEN = WORD_W;
`endif
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

    rxState_t             state, nextState;
    logic [WORD_W-1:0]    shiftReg, nextShift;
    logic [WORD_W-1:0]    outWord, nextOut;
    logic [CNT_W-1:0]     bitsLeft, nextBits;
    logic                 validReg, nextValid;
    logic                 errReg, nextErr;
    logic                 singleBit, conflict;
    logic [WORD_W-1:0]    shifted;

    assign singleBit = zero_bit ^ one_bit;
    assign conflict  = zero_bit & one_bit;
    assign shifted   = {shiftReg[WORD_W-2:0], one_bit};

    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        nextState = state;
        nextShift = shiftReg;
        nextBits  = bitsLeft;
        nextOut   = outWord;
        nextValid = 1'b0;
        nextErr   = 1'b0;

        if (start_bit) begin
            // A start inside a frame aborts it and reloads on the same edge.
            nextErr   = (state != IDLE);
            nextShift = '0;
            nextBits  = FRAME_LEN_C;
            nextState = SHIFT;
        end else if (state != IDLE && conflict) begin
            nextErr   = 1'b1;
            nextBits  = '0;
            nextState = IDLE;
        end else if (singleBit) begin
            case (state)
                SHIFT: begin
                    nextShift = shifted;
                    nextBits  = bitsLeft - ONE_C;
`ifdef SERIAL_WORD_RX_PARITY_EN
                    if (bitsLeft == CNT_W'(2)) nextState = PARITY;
`else
                    if (bitsLeft == ONE_C) begin
                        nextOut   = shifted;
                        nextValid = 1'b1;
                        nextState = IDLE;
                    end
`endif
                end
`ifdef SERIAL_WORD_RX_PARITY_EN
                PARITY: begin
                    nextBits  = '0;
                    nextState = IDLE;
                    if (one_bit == ^shiftReg) begin
                        nextOut   = shiftReg;
                        nextValid = 1'b1;
                    end else begin
                        nextErr   = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shiftReg <= '0;
            outWord  <= '0;
            bitsLeft <= '0;
            validReg <= 1'b0;
            errReg   <= 1'b0;
        end else begin
            state    <= nextState;
            shiftReg <= nextShift;
            outWord  <= nextOut;
            bitsLeft <= nextBits;
            validReg <= nextValid;
            errReg   <= nextErr;
        end
    end

    assign out_word   = outWord;
    assign word_valid = validReg;
    assign frame_err  = errReg;
    assign busy       = (state != IDLE);
    assign bits_left  = bitsLeft;

endmodule
